uart_crc_frame_tx: RTL and testbench
====================================

// Module: uart_crc_frame_tx
// PURPOSE
// - Parametrised UART framer/transmitter. Accepts a variable-length payload byte stream (valid/ready/last),
//   serialises each byte as an 8N1/8N2 character, LSB first, and accumulates a CRC over the payload.
// - After the last payload byte it appends CRC_WIDTH/8 CRC characters, MSB byte first.
// - Sits between the packet source and the tx pin; it is the multi-byte, configurable-CRC successor to the
//   single-byte CRC-16 transmitter.
// PARAMETERS
// - CLK_FREQ    50000000  system clock in Hz
// - BAUD_RATE   9600      line rate; DIV = CLK_FREQ/BAUD_RATE clocks per bit (integer division, DIV >= 2)
// - CRC_WIDTH   16        CRC size in bits; one of 8, 16, 32
// - CRC_POLY    'h1021    normal (MSB-first) polynomial, CRC_WIDTH bits
// - CRC_INIT    'hFFFF    CRC register value at frame start
// - CRC_XOROUT  'h0000    XOR applied to the final CRC before transmission
// - STOP_BITS   1         1 or 2 stop bits per character
// PORTS
// - clk         in   1          clock
// - reset       in   1          asynchronous, active-high
// - s_data      in   8          payload byte
// - s_valid     in   1          s_data valid
// - s_last      in   1          marks the final payload byte of the frame
// - s_ready     out  1          block accepts s_data this cycle
// - tx_out      out  1          serial line, idle high
// - tx_busy     out  1          frame in progress: first byte accepted until frame_done
// - frame_done  out  1          one-cycle pulse after the last CRC stop bit completes
// - crc_out     out  CRC_WIDTH  final CRC (post-XOROUT) of the last frame; holds until next frame_done
// BEHAVIOUR
// - Reset: tx_out=1, s_ready=1, tx_busy=0, frame_done=0, crc_out=0; FSM in IDLE; CRC reg=CRC_INIT.
//   Reset is honoured mid-character and mid-frame; the partial frame is discarded.
// - Handshake: a byte transfers when s_valid && s_ready. s_ready=1 only in IDLE and WAIT; 0 elsewhere.
// - FSM states:
//   - IDLE: accept byte -> START, tx_busy=1.
//   - START: tx_out=0 for DIV clocks -> DATA.
//   - DATA: bits 0..7 each for DIV clocks -> PARITY if enabled, else STOP.
//   - STOP: tx_out=1 for STOP_BITS*DIV clocks; then:
//     - payload byte, not last -> WAIT
//     - payload last -> CRC phase: load next CRC byte, START
//     - CRC byte, more remaining -> START with the next CRC byte
//     - final CRC byte -> IDLE, pulse frame_done, update crc_out, tx_busy=0, CRC reg=CRC_INIT
//   - WAIT: tx_out=1, s_ready=1; accept byte -> START. Stalls indefinitely (legal line idle).
// - Latency: the accept edge registers the byte. tx_out falls on the next clock and stays low exactly DIV clocks.
//   The baud counter restarts at every START, so there is no partial first bit.
// - Back-to-back: with s_valid held high, no idle bits between payload characters beyond the one WAIT cycle.
//   CRC characters follow the last payload stop bit with no gap.
// - CRC: updated at byte acceptance, 8 MSB-first shift/XOR steps on {crc ^ (byte << (CRC_WIDTH-8))},
//   no reflection. The CRC for a byte is complete before its START ends.
// - Single-byte frame (s_last on first byte) is legal. s_last/s_data are ignored when no transfer occurs.
// - Bit counter wraps 0..7; the baud counter counts 0..DIV-1 and wraps.
// CONFIGURATION
// - UART_CRC_PARITY_EN defined: a PARITY state sits after DATA. It sends the even-parity bit
//   (XOR of the 8 data bits) for DIV clocks, so each character is 11 (+1) bits.
// - UART_CRC_PARITY_EN not defined: no PARITY state, 8N1/8N2 framing only.
// STRUCTURE
// - uart_crc_pkg:
//   - tx_state_e enum (IDLE, START, DATA, PARITY, STOP, WAIT)
//   - crc_next_byte() function
//   - CRC_BYTES = CRC_WIDTH/8 constant
// - Sub-module uart_baud_tick:
//   - DIV-cycle counter with sync restart input
//   - outputs a one-cycle tick on the last cycle of each bit
// TESTING
// - Defaults, payload "123456789" (0x31..0x39, s_last on 0x39):
//   line carries 9 payload chars then 0x29, 0xB1; crc_out=0x29B1; one frame_done pulse.
// - Single byte 0xA5 with s_last, DIV=4:
//   tx_out low 4 clks, then 1,0,1,0,0,1,0,1 at 4 clks each, stop high.
//   3 chars in total; tx_busy drops with frame_done.
// - s_valid gaps of 100 clks between payload bytes:
//   tx_out stays 1 during the gaps; CRC is unchanged vs the gapless run; s_ready=1 only in WAIT/IDLE.
// - Assert reset mid DATA bit 3:
//   tx_out=1, s_ready=1, tx_busy=0 immediately.
//   The next frame "A" (0x41) with CRC-16 defaults gives crc_out=0xB915.
// - CRC_WIDTH=32, POLY='h04C11DB7, INIT='hFFFFFFFF, XOROUT='hFFFFFFFF, "123456789":
//   4 CRC chars FC,89,19,18 follow the payload.
// - UART_CRC_PARITY_EN defined, byte 0x07:
//   parity bit=1 after bit 7; each character is 11 bits × DIV clocks long.

Source files
------------

// File: rtl/uart_crc_pkg.sv
// Shared state encoding and the byte-wise CRC step for the UART CRC framer.
package uart_crc_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    WAIT   = 3'd5
  } tx_state_e;

  // MSB-first, non-reflected CRC over one byte; width is 8, 16 or 32.
  function automatic logic [31:0] crc_next_byte(input logic [31:0] crc,
                                                input logic [7:0]  data,
                                                input logic [31:0] poly,
                                                input int          width);
    logic [31:0] c;
    logic [31:0] msb;
    msb = 32'h1 << (width - 1);
    c   = crc ^ (32'(data) << (width - 8));
    for (int i = 0; i < 8; i++) begin
      c = ((c & msb) != 32'h0) ? ((c << 1) ^ poly) : (c << 1);
    end
    return c & ((msb << 1) - 32'h1);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: one-cycle tick on the last clock of every DIV-clock bit.
// A sync restart realigns the period so a character never begins with a partial bit.
module uart_baud_tick #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] cnt;

  assign tick = (cnt == W'(DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (restart || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/uart_crc_frame_tx.sv
// UART framer: payload bytes (valid/ready/last) go out 8N1/8N2 LSB first, then the CRC MSB byte first.
// s_ready only in IDLE/WAIT; optional even parity bit when UART_CRC_PARITY_EN is defined.
module uart_crc_frame_tx
  import uart_crc_pkg::*;
#(
  parameter int                   CLK_FREQ   = 50000000,
  parameter int                   BAUD_RATE  = 9600,
  parameter int                   CRC_WIDTH  = 16,
  parameter logic [CRC_WIDTH-1:0] CRC_POLY   = 'h1021,
  parameter logic [CRC_WIDTH-1:0] CRC_INIT   = 'hFFFF,
  parameter logic [CRC_WIDTH-1:0] CRC_XOROUT = 'h0000,
  parameter int                   STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           s_data,
  input  logic                 s_valid,
  input  logic                 s_last,
  output logic                 s_ready,
  output logic                 tx_out,
  output logic                 tx_busy,
  output logic                 frame_done,
  output logic [CRC_WIDTH-1:0] crc_out
);

  localparam int DIV       = CLK_FREQ / BAUD_RATE;
  localparam int CRC_BYTES = CRC_WIDTH / 8;

  localparam logic [2:0] S_IDLE   = IDLE;
  localparam logic [2:0] S_START  = START;
  localparam logic [2:0] S_DATA   = DATA;
`ifdef UART_CRC_PARITY_EN
  localparam logic [2:0] S_PARITY = PARITY;
`endif
  localparam logic [2:0] S_STOP   = STOP;
  localparam logic [2:0] S_WAIT   = WAIT;

  logic [2:0]           state;
  logic [7:0]           tx_byte;
  logic [2:0]           bit_cnt;
  logic                 stop_cnt;
  logic                 is_last;
  logic                 in_crc;
  logic [1:0]           crc_idx;
  logic [CRC_WIDTH-1:0] crc;

  logic                 tick;
  logic                 accept;
  logic                 stop_last;
  logic                 stop_end;
  logic                 chain;
  logic                 restart;
  logic [CRC_WIDTH-1:0] crc_fin;
  logic [1:0]           crc_idx_n;
  logic [7:0]           crc_byte_nxt;

  assign s_ready   = (state == S_IDLE) || (state == S_WAIT);
  assign tx_busy   = (state != S_IDLE);
  assign accept    = s_valid && s_ready;
  assign stop_last = (stop_cnt == 1'(STOP_BITS - 1));
  assign stop_end  = (state == S_STOP) && tick && stop_last;
  assign crc_fin   = crc ^ CRC_XOROUT;

  // Another character follows without a gap: first CRC byte after the last payload, or more CRC bytes.
  assign chain   = stop_end && ((!in_crc && is_last) ||
                                (in_crc && (int'(crc_idx) != CRC_BYTES - 1)));
  assign restart = accept || chain;

  always_comb begin
    crc_idx_n    = in_crc ? (crc_idx + 2'd1) : 2'd0;
    crc_byte_nxt = 8'h00;
    for (int i = 0; i < CRC_BYTES; i++) begin
      if (int'(crc_idx_n) == i) begin
        crc_byte_nxt = crc_fin[CRC_WIDTH-1-8*i -: 8];
      end
    end
  end

  uart_baud_tick #(
    .DIV(DIV)
  ) u_baud (
    .clk    (clk),
    .reset  (reset),
    .restart(restart),
    .tick   (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      tx_out     <= 1'b1;
      tx_byte    <= 8'h00;
      bit_cnt    <= 3'd0;
      stop_cnt   <= 1'b0;
      is_last    <= 1'b0;
      in_crc     <= 1'b0;
      crc_idx    <= 2'd0;
      crc        <= CRC_INIT;
      crc_out    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_IDLE, S_WAIT: begin
          if (accept) begin
            state   <= S_START;
            tx_out  <= 1'b0;
            tx_byte <= s_data;
            is_last <= s_last;
            in_crc  <= 1'b0;
            crc     <= CRC_WIDTH'(crc_next_byte(32'(crc), s_data, 32'(CRC_POLY), CRC_WIDTH));
          end
        end
        S_START: begin
          if (tick) begin
            state   <= S_DATA;
            bit_cnt <= 3'd0;
            tx_out  <= tx_byte[0];
          end
        end
        S_DATA: begin
          if (tick) begin
            if (bit_cnt == 3'd7) begin
`ifdef UART_CRC_PARITY_EN
              state    <= S_PARITY;
              tx_out   <= ^tx_byte;
`else
              state    <= S_STOP;
              tx_out   <= 1'b1;
              stop_cnt <= 1'b0;
`endif
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              tx_out  <= tx_byte[bit_cnt + 3'd1];
            end
          end
        end
`ifdef UART_CRC_PARITY_EN
        S_PARITY: begin
          if (tick) begin
            state    <= S_STOP;
            tx_out   <= 1'b1;
            stop_cnt <= 1'b0;
          end
        end
`endif
        S_STOP: begin
          if (tick) begin
            if (!stop_last) begin
              stop_cnt <= 1'b1;
            end else if (chain) begin
              state   <= S_START;
              tx_out  <= 1'b0;
              tx_byte <= crc_byte_nxt;
              in_crc  <= 1'b1;
              crc_idx <= crc_idx_n;
            end else if (in_crc) begin
              state      <= S_IDLE;
              frame_done <= 1'b1;
              crc_out    <= crc_fin;
              crc        <= CRC_INIT;
              in_crc     <= 1'b0;
            end else begin
              state <= S_WAIT;
            end
          end
        end
        default: begin
          state  <= S_IDLE;
          tx_out <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_crc_frame_tx.sv
// Directed bench: CRC-16 instance (a, 8N1) and CRC-32 instance (b, 8N2), both at 4 clocks per bit.
module tb_uart_crc_frame_tx;

  localparam int DIV = 4;
`ifdef UART_CRC_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int CB_A = 10 + PAR;
  localparam int CB_B = 11 + PAR;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  s_data;
  logic        s_last;
  logic        s_valid_a, s_valid_b;
  logic        s_ready_a, s_ready_b;
  logic        tx_out_a, tx_out_b;
  logic        tx_busy_a, tx_busy_b;
  logic        frame_done_a, frame_done_b;
  logic [15:0] crc_out_a;
  logic [31:0] crc_out_b;

  int     vectors = 0;
  int     miscompares = 0;
  longint cyc = 0;
  int     fd_cnt_a = 0;
  int     fd_cnt_b = 0;
  logic [7:0] q_a[$];
  logic [7:0] q_b[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (frame_done_a === 1'b1) fd_cnt_a++;
  always @(negedge clk) if (frame_done_b === 1'b1) fd_cnt_b++;

  uart_crc_frame_tx #(
    .CLK_FREQ(40), .BAUD_RATE(10)
  ) dut_a (
    .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid_a), .s_last(s_last),
    .s_ready(s_ready_a), .tx_out(tx_out_a), .tx_busy(tx_busy_a),
    .frame_done(frame_done_a), .crc_out(crc_out_a)
  );

  uart_crc_frame_tx #(
    .CLK_FREQ(40), .BAUD_RATE(10), .CRC_WIDTH(32), .CRC_POLY(32'h04C11DB7),
    .CRC_INIT(32'hFFFFFFFF), .CRC_XOROUT(32'hFFFFFFFF), .STOP_BITS(2)
  ) dut_b (
    .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid_b), .s_last(s_last),
    .s_ready(s_ready_b), .tx_out(tx_out_b), .tx_busy(tx_busy_b),
    .frame_done(frame_done_b), .crc_out(crc_out_b)
  );

  // Line receivers: sample mid-bit, skip the parity bit, push each character byte.
  initial begin
    forever begin
      @(negedge clk);
      if (tx_out_a === 1'b0 && reset === 1'b0) begin
        logic [7:0] rx;
        repeat (DIV / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clk);
          rx[i] = tx_out_a;
        end
        repeat (DIV * (1 + PAR)) @(negedge clk);
        q_a.push_back(rx);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (tx_out_b === 1'b0 && reset === 1'b0) begin
        logic [7:0] rx;
        repeat (DIV / 2) @(negedge clk);
        for (int j = 0; j < 8; j++) begin
          repeat (DIV) @(negedge clk);
          rx[j] = tx_out_b;
        end
        repeat (DIV * (1 + PAR)) @(negedge clk);
        q_b.push_back(rx);
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic l, input bit to_b);
    int n = 0;
    s_data = d;
    s_last = l;
    if (to_b) s_valid_b = 1'b1; else s_valid_a = 1'b1;
    while (n < 2000 && !(to_b ? s_ready_b : s_ready_a)) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: s_ready low for %0d cycles, required high", n);
    end
    @(posedge clk);
    #1;
    s_valid_a = 1'b0;
    s_valid_b = 1'b0;
  endtask

  task automatic wait_done(input bit on_b, output longint td);
    int n = 0;
    td = -1;
    while (n < 5000 && td < 0) begin
      @(negedge clk);
      n++;
      if ((on_b ? frame_done_b : frame_done_a) === 1'b1) td = cyc;
    end
    vectors++;
    if (td < 0) begin
      miscompares++;
      $display("FAIL frame_done_timeout: no pulse in %0d cycles, required one", n);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    s_valid_a = 1'b0;
    s_valid_b = 1'b0;
    s_data = 8'h00;
    s_last = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    vectors++; if (tx_out_a !== 1'b1) begin miscompares++; $display("FAIL reset_tx_out: got %b want 1", tx_out_a); end
    vectors++; if (s_ready_a !== 1'b1) begin miscompares++; $display("FAIL reset_s_ready: got %b want 1", s_ready_a); end
    vectors++; if (tx_busy_a !== 1'b0) begin miscompares++; $display("FAIL reset_tx_busy: got %b want 0", tx_busy_a); end
    vectors++; if (frame_done_a !== 1'b0) begin miscompares++; $display("FAIL reset_frame_done: got %b want 0", frame_done_a); end
    vectors++; if (crc_out_a !== 16'h0000) begin miscompares++; $display("FAIL reset_crc_out: got %h want 0000", crc_out_a); end
    vectors++; if (crc_out_b !== 32'h0) begin miscompares++; $display("FAIL reset_crc_out_b: got %h want 00000000", crc_out_b); end
  endtask

  task automatic test_single_byte;
    logic [0:7] seq = 8'b10100101;
    logic [7:0] exp_q[$];
    logic       e;
    longint     t0, td;
    int         qb, fb, idx;
    exp_q = '{8'hA5, 8'h04, 8'hBF};
    qb = q_a.size();
    fb = fd_cnt_a;
    send(8'hA5, 1'b1, 1'b0);
    t0 = cyc;
    for (int k = 0; k < CB_A * DIV; k++) begin
      @(negedge clk);
      idx = k / DIV;
      if (idx == 0) e = 1'b0;
      else if (idx <= 8) e = seq[idx-1];
      else if (PAR == 1 && idx == 9) e = 1'b0;
      else e = 1'b1;
      vectors++;
      if (tx_out_a !== e) begin miscompares++; $display("FAIL a5_wave[%0d]: got %b want %b", k, tx_out_a, e); end
      if (k == 0) begin
        vectors++;
        if (tx_busy_a !== 1'b1 || s_ready_a !== 1'b0) begin
          miscompares++;
          $display("FAIL a5_busy_ready: got busy=%b ready=%b want 1/0", tx_busy_a, s_ready_a);
        end
      end
    end
    wait_done(1'b0, td);
    vectors++; if (td - t0 != 3 * CB_A * DIV) begin miscompares++; $display("FAIL a5_frame_len: got %0d want %0d", td - t0, 3 * CB_A * DIV); end
    vectors++; if (tx_busy_a !== 1'b0) begin miscompares++; $display("FAIL a5_busy_drop: got %b want 0", tx_busy_a); end
    @(negedge clk);
    vectors++; if (frame_done_a !== 1'b0) begin miscompares++; $display("FAIL a5_done_width: got %b want 0", frame_done_a); end
    vectors++; if (crc_out_a !== 16'h04BF) begin miscompares++; $display("FAIL a5_crc: got %h want 04BF", crc_out_a); end
    vectors++; if (fd_cnt_a - fb != 1) begin miscompares++; $display("FAIL a5_done_count: got %0d want 1", fd_cnt_a - fb); end
    vectors++;
    if (q_a.size() - qb != 3) begin miscompares++; $display("FAIL a5_char_count: got %0d want 3", q_a.size() - qb); end
    else for (int i = 0; i < 3; i++) begin
      vectors++;
      if (q_a[qb+i] !== exp_q[i]) begin miscompares++; $display("FAIL a5_char[%0d]: got %h want %h", i, q_a[qb+i], exp_q[i]); end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp_q[$];
    longint     t0, td;
    int         qb, fb;
    exp_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h29, 8'hB1};
    qb = q_a.size();
    fb = fd_cnt_a;
    t0 = 0;
    for (int i = 0; i < 9; i++) begin
      send(8'h31 + 8'(i), (i == 8), 1'b0);
      if (i == 0) t0 = cyc;
    end
    wait_done(1'b0, td);
    vectors++; if (td - t0 != 11 * CB_A * DIV + 8) begin miscompares++; $display("FAIL b2b_frame_len: got %0d want %0d", td - t0, 11 * CB_A * DIV + 8); end
    @(negedge clk);
    vectors++; if (crc_out_a !== 16'h29B1) begin miscompares++; $display("FAIL b2b_crc: got %h want 29B1", crc_out_a); end
    vectors++; if (fd_cnt_a - fb != 1) begin miscompares++; $display("FAIL b2b_done_count: got %0d want 1", fd_cnt_a - fb); end
    vectors++;
    if (q_a.size() - qb != 11) begin miscompares++; $display("FAIL b2b_char_count: got %0d want 11", q_a.size() - qb); end
    else for (int i = 0; i < 11; i++) begin
      vectors++;
      if (q_a[qb+i] !== exp_q[i]) begin miscompares++; $display("FAIL b2b_char[%0d]: got %h want %h", i, q_a[qb+i], exp_q[i]); end
    end
  endtask

  task automatic test_gaps;
    longint td;
    int     qb, n;
    bit     bad;
    qb = q_a.size();
    for (int i = 0; i < 9; i++) begin
      send(8'h31 + 8'(i), (i == 8), 1'b0);
      if (i < 8) begin
        n = 0;
        @(negedge clk);
        while (!s_ready_a && n < 1000) begin n++; @(negedge clk); end
        vectors++;
        if (n != CB_A * DIV) begin miscompares++; $display("FAIL gap_ready_low[%0d]: got %0d cycles want %0d", i, n, CB_A * DIV); end
        bad = 1'b0;
        repeat (100) begin
          if (tx_out_a !== 1'b1 || s_ready_a !== 1'b1) bad = 1'b1;
          @(negedge clk);
        end
        vectors++;
        if (bad) begin miscompares++; $display("FAIL gap_idle[%0d]: got line/ready not held at 1, want 1/1", i); end
      end
    end
    wait_done(1'b0, td);
    @(negedge clk);
    vectors++; if (crc_out_a !== 16'h29B1) begin miscompares++; $display("FAIL gap_crc: got %h want 29B1", crc_out_a); end
    vectors++;
    if (q_a.size() - qb != 11) begin miscompares++; $display("FAIL gap_char_count: got %0d want 11", q_a.size() - qb); end
    else begin
      vectors++;
      if (q_a[qb+9] !== 8'h29 || q_a[qb+10] !== 8'hB1) begin
        miscompares++;
        $display("FAIL gap_crc_chars: got %h %h want 29 B1", q_a[qb+9], q_a[qb+10]);
      end
    end
  endtask

  task automatic test_reset_mid;
    longint td;
    int     qb, fb;
    send(8'h55, 1'b0, 1'b0);
    repeat (18) @(negedge clk);
    vectors++; if (tx_busy_a !== 1'b1) begin miscompares++; $display("FAIL mid_busy_before: got %b want 1", tx_busy_a); end
    reset = 1'b1;
    #1;
    vectors++; if (tx_out_a !== 1'b1) begin miscompares++; $display("FAIL mid_tx_out: got %b want 1", tx_out_a); end
    vectors++; if (s_ready_a !== 1'b1) begin miscompares++; $display("FAIL mid_s_ready: got %b want 1", s_ready_a); end
    vectors++; if (tx_busy_a !== 1'b0) begin miscompares++; $display("FAIL mid_tx_busy: got %b want 0", tx_busy_a); end
    vectors++; if (crc_out_a !== 16'h0000) begin miscompares++; $display("FAIL mid_crc_out: got %h want 0000", crc_out_a); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (60) @(negedge clk);
    qb = q_a.size();
    fb = fd_cnt_a;
    send(8'h41, 1'b1, 1'b0);
    wait_done(1'b0, td);
    @(negedge clk);
    vectors++; if (crc_out_a !== 16'hB915) begin miscompares++; $display("FAIL mid_next_crc: got %h want B915", crc_out_a); end
    vectors++; if (fd_cnt_a - fb != 1) begin miscompares++; $display("FAIL mid_done_count: got %0d want 1", fd_cnt_a - fb); end
    vectors++;
    if (q_a.size() - qb != 3) begin miscompares++; $display("FAIL mid_char_count: got %0d want 3", q_a.size() - qb); end
    else begin
      vectors++;
      if (q_a[qb] !== 8'h41 || q_a[qb+1] !== 8'hB9 || q_a[qb+2] !== 8'h15) begin
        miscompares++;
        $display("FAIL mid_chars: got %h %h %h want 41 B9 15", q_a[qb], q_a[qb+1], q_a[qb+2]);
      end
    end
  endtask

  task automatic test_crc32;
    logic [7:0] exp_q[$];
    longint     t0, td;
    int         qb, fb;
    exp_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
              8'hFC, 8'h89, 8'h19, 8'h18};
    qb = q_b.size();
    fb = fd_cnt_b;
    t0 = 0;
    for (int i = 0; i < 9; i++) begin
      send(8'h31 + 8'(i), (i == 8), 1'b1);
      if (i == 0) t0 = cyc;
    end
    wait_done(1'b1, td);
    vectors++; if (td - t0 != 13 * CB_B * DIV + 8) begin miscompares++; $display("FAIL crc32_frame_len: got %0d want %0d", td - t0, 13 * CB_B * DIV + 8); end
    @(negedge clk);
    vectors++; if (crc_out_b !== 32'hFC891918) begin miscompares++; $display("FAIL crc32_value: got %h want FC891918", crc_out_b); end
    vectors++; if (fd_cnt_b - fb != 1) begin miscompares++; $display("FAIL crc32_done_count: got %0d want 1", fd_cnt_b - fb); end
    vectors++;
    if (q_b.size() - qb != 13) begin miscompares++; $display("FAIL crc32_char_count: got %0d want 13", q_b.size() - qb); end
    else for (int i = 0; i < 13; i++) begin
      vectors++;
      if (q_b[qb+i] !== exp_q[i]) begin miscompares++; $display("FAIL crc32_char[%0d]: got %h want %h", i, q_b[qb+i], exp_q[i]); end
    end
  endtask

`ifdef UART_CRC_PARITY_EN
  task automatic test_parity;
    longint t0, td;
    int     qb;
    qb = q_a.size();
    send(8'h07, 1'b1, 1'b0);
    t0 = cyc;
    repeat (9 * DIV + 2) @(negedge clk);
    vectors++; if (tx_out_a !== 1'b1) begin miscompares++; $display("FAIL parity_bit: got %b want 1", tx_out_a); end
    repeat (DIV) @(negedge clk);
    vectors++; if (tx_out_a !== 1'b1) begin miscompares++; $display("FAIL parity_stop: got %b want 1", tx_out_a); end
    wait_done(1'b0, td);
    vectors++; if (td - t0 != 3 * 11 * DIV) begin miscompares++; $display("FAIL parity_frame_len: got %0d want %0d", td - t0, 3 * 11 * DIV); end
    @(negedge clk);
    vectors++;
    if (q_a.size() - qb != 3 || q_a[qb] !== 8'h07) begin
      miscompares++;
      $display("FAIL parity_chars: got %0d chars, first %h; want 3 chars, first 07", q_a.size() - qb, q_a[qb]);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_gaps();
    test_reset_mid();
    test_crc32();
`ifdef UART_CRC_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
